// File: rtl/bitty_uart_link.sv
// Full-duplex UART: TX FIFO feeding a serialiser, RX deserialiser into a ready/valid holding register.
// Latency: push to start bit 2 cycles; RX word visible 1 cycle after the stop-bit sample.
// Backpressure: tx_ready low when FIFO full; RX overwrites nothing, drops new word with rx_overflow when held.
// Optional even parity bit enabled by defining BITTY_UART_PARITY_EN.
module bitty_uart_link #(
    parameter int DATA_W   = 8,
    parameter int DIV_W    = 13,
    parameter int TX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  clks_per_bit,
    input  logic              rx_data_bit,
    output logic              tx_data_bit,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_busy,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_frame_err,
    output logic              rx_parity_err,
    output logic              rx_overflow
);

    localparam int AW    = $clog2(TX_DEPTH);
    localparam int IDX_W = $clog2(DATA_W + 1);
`ifdef BITTY_UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT
    } rx_state_t;

    logic [DIV_W-1:0] w_div;
    assign w_div = (clks_per_bit < DIV_W'(2)) ? DIV_W'(2) : clks_per_bit;

    // ---------------- TX FIFO ----------------
    logic [DATA_W-1:0] r_fifo [TX_DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_tx_load;
    logic [DATA_W-1:0] w_fifo_head;

    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push      = tx_valid & ~w_full;
    assign w_fifo_head = r_fifo[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[AW-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_tx_load) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // ---------------- TX serialiser ----------------
    tx_state_t         r_tx_state;
    tx_state_t         w_tx_state_nxt;
    logic [DIV_W-1:0]  r_tx_div;
    logic [DIV_W-1:0]  r_tx_cnt;
    logic [IDX_W-1:0]  r_tx_idx;
    logic [DATA_W-1:0] r_tx_shift;
    logic              r_tx_par;
    logic              r_tx_bit;
    logic              w_tx_bit_nxt;
    logic              w_tx_bit_end;

    assign w_tx_bit_end = (r_tx_cnt == r_tx_div - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
        end else begin
            r_tx_state <= w_tx_state_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_load      = 1'b0;
        w_tx_bit_nxt   = r_tx_bit;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_bit_nxt = 1'b1;
                if (!w_empty) begin
                    w_tx_load      = 1'b1;
                    w_tx_state_nxt = TX_START;
                    w_tx_bit_nxt   = 1'b0;
                end
            end
            TX_START: begin
                if (w_tx_bit_end) begin
                    w_tx_state_nxt = TX_DATA;
                    w_tx_bit_nxt   = r_tx_shift[0];
                end
            end
            TX_DATA: begin
                if (w_tx_bit_end) begin
                    if (r_tx_idx == IDX_W'(DATA_W - 1)) begin
                        if (PAR_EN) begin
                            w_tx_state_nxt = TX_PAR;
                            w_tx_bit_nxt   = r_tx_par;
                        end else begin
                            w_tx_state_nxt = TX_STOP;
                            w_tx_bit_nxt   = 1'b1;
                        end
                    end else begin
                        w_tx_bit_nxt = r_tx_shift[1];
                    end
                end
            end
            TX_PAR: begin
                if (w_tx_bit_end) begin
                    w_tx_state_nxt = TX_STOP;
                    w_tx_bit_nxt   = 1'b1;
                end
            end
            TX_STOP: begin
                if (w_tx_bit_end) begin
                    // Chain straight into the next start bit when more data is queued.
                    if (!w_empty) begin
                        w_tx_load      = 1'b1;
                        w_tx_state_nxt = TX_START;
                        w_tx_bit_nxt   = 1'b0;
                    end else begin
                        w_tx_state_nxt = TX_IDLE;
                        w_tx_bit_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                w_tx_state_nxt = TX_IDLE;
                w_tx_bit_nxt   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_bit   <= 1'b1;
            r_tx_div   <= DIV_W'(2);
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
        end else begin
            r_tx_bit <= w_tx_bit_nxt;
            if (w_tx_load) begin
                r_tx_shift <= w_fifo_head;
                r_tx_par   <= ^w_fifo_head;
                r_tx_div   <= w_div;
                r_tx_cnt   <= '0;
                r_tx_idx   <= '0;
            end else if (r_tx_state != TX_IDLE) begin
                if (w_tx_bit_end) begin
                    r_tx_cnt <= '0;
                    if (r_tx_state == TX_DATA) begin
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_idx   <= r_tx_idx + 1'b1;
                    end
                end else begin
                    r_tx_cnt <= r_tx_cnt + 1'b1;
                end
            end
        end
    end

    assign tx_data_bit = r_tx_bit;
    assign tx_ready    = ~w_full;
    assign tx_busy     = (r_tx_state != TX_IDLE) | ~w_empty;

    // ---------------- RX deserialiser ----------------
    logic              r_rx_s1;
    logic              r_rx_s2;
    logic              r_rx_s3;
    logic              w_rx_line;
    logic              w_rx_fall;
    rx_state_t         r_rx_state;
    rx_state_t         w_rx_state_nxt;
    logic [DIV_W-1:0]  r_rx_div;
    logic [DIV_W-1:0]  r_rx_cnt;
    logic [IDX_W-1:0]  r_rx_idx;
    logic [DATA_W-1:0] r_rx_shift;
    logic              r_rx_par_bit;
    logic              w_rx_half_hit;
    logic              w_rx_bit_end;
    logic              w_rx_start;
    logic              w_rx_sample;
    logic              w_rx_par_smp;
    logic              w_rx_good;
    logic              w_rx_ferr;
    logic              w_rx_perr;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_rx_ferr;
    logic              r_rx_perr;
    logic              r_rx_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= rx_data_bit;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    assign w_rx_line     = r_rx_s2;
    assign w_rx_fall     = r_rx_s3 & ~r_rx_s2;
    assign w_rx_half_hit = (r_rx_cnt == (r_rx_div >> 1));
    assign w_rx_bit_end  = (r_rx_cnt == r_rx_div - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_state <= w_rx_state_nxt;
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_start     = 1'b0;
        w_rx_sample    = 1'b0;
        w_rx_par_smp   = 1'b0;
        w_rx_good      = 1'b0;
        w_rx_ferr      = 1'b0;
        w_rx_perr      = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_rx_fall) begin
                    w_rx_start     = 1'b1;
                    w_rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (w_rx_half_hit) begin
                    w_rx_state_nxt = w_rx_line ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_rx_bit_end) begin
                    w_rx_sample = 1'b1;
                    if (r_rx_idx == IDX_W'(DATA_W - 1)) begin
                        w_rx_state_nxt = PAR_EN ? RX_PAR : RX_STOP;
                    end
                end
            end
            RX_PAR: begin
                if (w_rx_bit_end) begin
                    w_rx_par_smp   = 1'b1;
                    w_rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_rx_bit_end) begin
                    // Framing error wins; only one error pulse per frame.
                    if (!w_rx_line) begin
                        w_rx_ferr      = 1'b1;
                        w_rx_state_nxt = RX_WAIT;
                    end else if (PAR_EN && ((^r_rx_shift) != r_rx_par_bit)) begin
                        w_rx_perr      = 1'b1;
                        w_rx_state_nxt = RX_IDLE;
                    end else begin
                        w_rx_good      = 1'b1;
                        w_rx_state_nxt = RX_IDLE;
                    end
                end
            end
            RX_WAIT: begin
                if (w_rx_line) begin
                    w_rx_state_nxt = RX_IDLE;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_div     <= DIV_W'(2);
            r_rx_cnt     <= '0;
            r_rx_idx     <= '0;
            r_rx_shift   <= '0;
            r_rx_par_bit <= 1'b0;
        end else if (w_rx_start) begin
            // The detect cycle already counts as the first cycle of the start bit.
            r_rx_div <= w_div;
            r_rx_cnt <= DIV_W'(1);
            r_rx_idx <= '0;
        end else begin
            case (r_rx_state)
                RX_START:                r_rx_cnt <= w_rx_half_hit ? '0 : r_rx_cnt + 1'b1;
                RX_DATA, RX_PAR, RX_STOP: r_rx_cnt <= w_rx_bit_end ? '0 : r_rx_cnt + 1'b1;
                default:                 r_rx_cnt <= '0;
            endcase
            if (w_rx_sample) begin
                r_rx_shift <= {w_rx_line, r_rx_shift[DATA_W-1:1]};
                r_rx_idx   <= r_rx_idx + 1'b1;
            end
            if (w_rx_par_smp) begin
                r_rx_par_bit <= w_rx_line;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            r_rx_perr  <= 1'b0;
            r_rx_ovf   <= 1'b0;
        end else begin
            r_rx_ferr <= w_rx_ferr;
            r_rx_perr <= w_rx_perr;
            r_rx_ovf  <= 1'b0;
            if (w_rx_good) begin
                if (r_rx_valid && !rx_ready) begin
                    r_rx_ovf <= 1'b1;
                end else begin
                    r_rx_data  <= r_rx_shift;
                    r_rx_valid <= 1'b1;
                end
            end else if (rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign rx_frame_err = r_rx_ferr;
    assign rx_overflow  = r_rx_ovf;
`ifdef BITTY_UART_PARITY_EN
    assign rx_parity_err = r_rx_perr;
`else
    assign rx_parity_err = r_rx_perr & 1'b0;
`endif

endmodule

// File: tb/tb_bitty_uart_link.sv
// Directed bench for bitty_uart_link: TX timing, FIFO backpressure, loopback RX, error and reset cases.
module tb_bitty_uart_link;
`ifdef BITTY_UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB = 10 + PB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] clks_per_bit;
    logic        rx_line;
    logic        tx_data_bit;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_frame_err;
    logic        rx_parity_err;
    logic        rx_overflow;
    logic        loop_en;
    logic        rx_drv;

    int n_chk  = 0;
    int n_fail = 0;
    int n_ferr = 0;
    int n_perr = 0;
    int n_ovf  = 0;

    always #5 clk = ~clk;
    assign rx_line = loop_en ? tx_data_bit : rx_drv;

    bitty_uart_link dut (
        .clk(clk), .rst_n(rst_n), .clks_per_bit(clks_per_bit),
        .rx_data_bit(rx_line), .tx_data_bit(tx_data_bit),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .rx_overflow(rx_overflow)
    );

    always @(negedge clk) begin
        if (rx_frame_err)  n_ferr++;
        if (rx_parity_err) n_perr++;
        if (rx_overflow)   n_ovf++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] w, input int b);
        if (b == 0)              return 1'b0;
        else if (b <= 8)         return w[b-1];
        else if (PB == 1 && b == 9) return ^w;
        else                     return 1'b1;
    endfunction

    task automatic push(input logic [7:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int c = 0;
        while (tx_busy && c < budget) begin
            tick();
            c++;
        end
        chk(tag, {31'd0, tx_busy}, 32'd0);
    endtask

    task automatic drive_frame(input logic [7:0] w, input logic stop_b, input logic par_bad);
        for (int b = 0; b < NB; b++) begin
            if (b == NB - 1) rx_drv = stop_b;
            else if (PB == 1 && b == 9) rx_drv = exp_bit(w, b) ^ par_bad;
            else rx_drv = exp_bit(w, b);
            repeat (16) tick();
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        logic [7:0] words [5];
        logic [7:0] lw [3];
        int got;
        int cyc;
        int base_f;
        int base_p;
        int base_o;

        rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
        loop_en = 1'b0; rx_drv = 1'b1; clks_per_bit = 13'd4;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_bit",  {31'd0, tx_data_bit}, 32'd1);
        chk("rst_tx_ready", {31'd0, tx_ready},   32'd1);
        chk("rst_tx_busy", {31'd0, tx_busy},     32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid},   32'd0);
        chk("rst_rx_data", {24'd0, rx_data},     32'd0);
        chk("rst_pulses", {29'd0, rx_frame_err, rx_parity_err, rx_overflow}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single frame 0xA5 at div=4, checked every cycle from N+2.
        push(8'hA5);
        chk("t1_n1_idle_line", {31'd0, tx_data_bit}, 32'd1);
        chk("t1_n1_busy", {31'd0, tx_busy}, 32'd1);
        tick();
        for (int i = 0; i < 4 * NB; i++) begin
            chk($sformatf("t1_bit_c%0d", i), {31'd0, tx_data_bit}, {31'd0, exp_bit(8'hA5, i / 4)});
            tick();
        end
        chk("t1_busy_end", {31'd0, tx_busy}, 32'd0);
        chk("t1_line_end", {31'd0, tx_data_bit}, 32'd1);

        // Five pushes fill the FIFO; frames go out back-to-back.
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h3C; words[3] = 8'h81; words[4] = 8'hF0;
        for (int k = 0; k < 5; k++) begin
            tx_data  = words[k];
            tx_valid = 1'b1;
            tick();
        end
        tx_valid = 1'b0;
        chk("t2_full_ready", {31'd0, tx_ready}, 32'd0);
        for (int i = 3; i < 5 * 4 * NB; i++) begin
            chk($sformatf("t2_bit_c%0d", i), {31'd0, tx_data_bit},
                {31'd0, exp_bit(words[i / (4 * NB)], (i % (4 * NB)) / 4)});
            tick();
        end
        chk("t2_busy_end", {31'd0, tx_busy}, 32'd0);
        chk("t2_ready_end", {31'd0, tx_ready}, 32'd1);

        // Divisor below 2 is clamped to 2.
        clks_per_bit = 13'd0;
        push(8'hFF);
        tick();
        chk("div0_start_a", {31'd0, tx_data_bit}, 32'd0);
        tick();
        chk("div0_start_b", {31'd0, tx_data_bit}, 32'd0);
        tick();
        chk("div0_bit0", {31'd0, tx_data_bit}, 32'd1);
        wait_idle("div0_idle_timeout", 200);

        // Loopback at div=16.
        clks_per_bit = 13'd16;
        loop_en = 1'b1; rx_ready = 1'b1;
        base_f = n_ferr; base_p = n_perr; base_o = n_ovf;
        lw[0] = 8'h00; lw[1] = 8'hFF; lw[2] = 8'h3C;
        for (int k = 0; k < 3; k++) push(lw[k]);
        got = 0; cyc = 0;
        while (got < 3 && cyc < 3 * 16 * NB + 400) begin
            if (rx_valid) begin
                chk($sformatf("t3_word%0d", got), {24'd0, rx_data}, {24'd0, lw[got]});
                got++;
            end
            tick();
            cyc++;
        end
        chk("t3_word_count", got, 3);
        chk("t3_no_errors", (n_ferr - base_f) + (n_perr - base_p) + (n_ovf - base_o), 0);
        wait_idle("t3_idle_timeout", 400);

        // Held word plus a second frame -> one overflow, first word kept.
        rx_ready = 1'b0;
        base_o = n_ovf;
        push(8'h5A);
        push(8'hC3);
        wait_idle("t4_idle_timeout", 2 * 16 * NB + 100);
        repeat (4) tick();
        chk("t4_valid_held", {31'd0, rx_valid}, 32'd1);
        chk("t4_data_kept", {24'd0, rx_data}, 32'h5A);
        chk("t4_ovf_count", n_ovf - base_o, 1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("t4_consumed", {31'd0, rx_valid}, 32'd0);

        // Bad stop bit, then a short glitch, then a good frame.
        loop_en = 1'b0;
        base_f = n_ferr; base_p = n_perr;
        drive_frame(8'h55, 1'b0, 1'b0);
        repeat (40) tick();
        chk("t5_ferr_count", n_ferr - base_f, 1);
        chk("t5_no_valid", {31'd0, rx_valid}, 32'd0);
        chk("t5_no_perr", n_perr - base_p, 0);
        base_f = n_ferr;
        rx_drv = 1'b0;
        repeat (2) tick();
        rx_drv = 1'b1;
        repeat (40) tick();
        chk("t5_glitch_valid", {31'd0, rx_valid}, 32'd0);
        chk("t5_glitch_ferr", n_ferr - base_f, 0);
        drive_frame(8'h96, 1'b1, 1'b0);
        repeat (20) tick();
        chk("t5_good_valid", {31'd0, rx_valid}, 32'd1);
        chk("t5_good_data", {24'd0, rx_data}, 32'h96);

        // Async reset in the middle of a data bit.
        push(8'h00);
        push(8'hFF);
        repeat (40) tick();
        chk("t6_mid_data_line", {31'd0, tx_data_bit}, 32'd0);
        chk("t6_mid_busy", {31'd0, tx_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_line", {31'd0, tx_data_bit}, 32'd1);
        chk("t6_rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("t6_rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("t6_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("t6_rst_rx_data", {24'd0, rx_data}, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (50) tick();
        chk("t6_after_line", {31'd0, tx_data_bit}, 32'd1);
        chk("t6_after_busy", {31'd0, tx_busy}, 32'd0);

`ifdef BITTY_UART_PARITY_EN
        base_f = n_ferr; base_p = n_perr;
        drive_frame(8'h01, 1'b1, 1'b1);
        repeat (20) tick();
        chk("par_perr_count", n_perr - base_p, 1);
        chk("par_no_ferr", n_ferr - base_f, 0);
        chk("par_dropped", {31'd0, rx_valid}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
